// File: rtl/forward_net_pkg.sv
// Shared types and timing helpers for the forward-network sequencer.
// Used by the sequencer top, its layer timer and the bench.
package forward_net_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } seq_state_t;

  function automatic int strobe_offset(input int k, input int lc);
    return 1 + k * lc;
  endfunction

  function automatic int valid_offset(input int tl, input int lc);
    return 2 + tl * lc;
  endfunction

endpackage

// File: rtl/forward_net_sequencer_layer_timer.sv
// Settle-time counter between layer strobes.
// term_o pulses on the cycle the count reaches LAYER_CYCLES.
module layer_timer #(
  parameter int LAYER_CYCLES = 4,
  parameter int W = $clog2(LAYER_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [W-1:0] LAST = W'(LAYER_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds completed cycles; the cycle being entered is cnt_q+1
  assign term_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/forward_net_sequencer.sv
// Sequences one inference: strobes layer banks input-first, waits a
// fixed settle time between layers, then holds result-valid until taken.
module forward_net_sequencer
  import forward_net_pkg::*;
#(
  parameter int TOTAL_LAYERS = 3,
  parameter int LAYER_CYCLES = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(TOTAL_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [TOTAL_LAYERS:0]   sample_data,
  output logic [IDX_W-1:0]        layer_idx,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        done_count
);

  localparam int SW = TOTAL_LAYERS + 1;
  localparam logic [SW-1:0] STROBE0 = SW'(1);

  seq_state_t       state_q, state_d;
  logic [SW-1:0]    sample_q, sample_d;
  logic [IDX_W-1:0] layer_q, layer_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tmr_load, tmr_en, tmr_term;

  layer_timer #(
    .LAYER_CYCLES(LAYER_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .load_i(tmr_load),
    .en_i  (tmr_en),
    .term_o(tmr_term)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = '0;
    layer_d  = layer_q;
    valid_d  = valid_q;
    count_d  = count_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = LOAD;
      end
      LOAD: begin
        state_d  = COMPUTE;
        sample_d = STROBE0;
        layer_d  = '0;
        tmr_load = 1'b1;
      end
      COMPUTE: begin
        tmr_en = 1'b1;
        // final strobe is on the bus now: result is stable next cycle
        if (sample_q[TOTAL_LAYERS]) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else if (tmr_term) begin
          layer_d  = layer_q + 1'b1;
          sample_d = STROBE0 << layer_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          layer_d = '0;
          count_d = count_q + 1'b1;
        end
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      sample_d = '0;
      valid_d  = 1'b0;
      layer_d  = '0;
      count_d  = count_q;
      tmr_load = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      layer_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      layer_q  <= layer_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign in_ready    = reset && (state_q == IDLE);
  assign sample_data = sample_q;
  assign layer_idx   = layer_q;
  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign done_count  = count_q;

endmodule

// File: tb/tb_forward_net_sequencer.sv
// Directed bench: default config, a 2-bit counter copy sharing its
// stimulus, and a TOTAL_LAYERS=2 / LAYER_CYCLES=1 variant.
module tb_forward_net_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic iv0, or0, fl0;
  logic iv1, or1, fl1;

  logic        ir0, bz0, ov0;
  logic [3:0]  sd0;
  logic [1:0]  li0;
  logic [15:0] dc0;

  logic        ir2, bz2, ov2;
  logic [3:0]  sd2;
  logic [1:0]  li2;
  logic [1:0]  dc2;

  logic        ir1, bz1, ov1;
  logic [2:0]  sd1;
  logic [1:0]  li1;
  logic [15:0] dc1;

  int checks = 0;
  int errors = 0;

  forward_net_sequencer u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
    .flush(fl0), .sample_data(sd0), .layer_idx(li0), .busy(bz0),
    .out_valid(ov0), .out_ready(or0), .done_count(dc0)
  );

  forward_net_sequencer #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir2),
    .flush(fl0), .sample_data(sd2), .layer_idx(li2), .busy(bz2),
    .out_valid(ov2), .out_ready(or0), .done_count(dc2)
  );

  forward_net_sequencer #(.TOTAL_LAYERS(2), .LAYER_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .flush(fl1), .sample_data(sd1), .layer_idx(li1), .busy(bz1),
    .out_valid(ov1), .out_ready(or1), .done_count(dc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_strobe(input int c);
    case (c)
      1:  return 4'b0001;
      5:  return 4'b0010;
      9:  return 4'b0100;
      13: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always @(negedge clk) begin
    checks++;
    assert ($onehot0(sd0) && $onehot0(sd1) && $onehot0(sd2)) else begin
      errors++;
      $error("FAIL onehot: observed %b/%b/%b expected onehot0",
             sd0, sd1, sd2);
    end
  end

  task automatic run(input int hold, input logic hammer, input int n);
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    chk("busy_load", 32'(bz0), 32'd1);
    chk("ready_load", 32'(ir0), 32'd0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("strobe", 32'(sd0), 32'(exp_strobe(c)));
      chk("valid", 32'(ov0), (c == 14) ? 32'd1 : 32'd0);
      if (exp_strobe(c) != 4'b0000)
        chk("layer", 32'(li0), 32'((c - 1) / 4));
    end
    for (int h = 0; h < hold; h++) begin
      iv0 = hammer;
      tick();
      chk("hold_valid", 32'(ov0), 32'd1);
      chk("hold_ready", 32'(ir0), 32'd0);
      chk("hold_strobe", 32'(sd0), 32'd0);
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    tick();
    or0 = 1'b0;
    chk("count", 32'(dc0), 32'(n));
    chk("count2", 32'(dc2), 32'(n % 4));
    chk("valid_clr", 32'(ov0), 32'd0);
    chk("ready_back", 32'(ir0), 32'd1);
    chk("busy_clr", 32'(bz0), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    iv0 = 1'b1; or0 = 1'b0; fl0 = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0;
    repeat (2) tick();
    chk("rst_strobe", 32'(sd0), 32'd0);
    chk("rst_layer", 32'(li0), 32'd0);
    chk("rst_busy", 32'(bz0), 32'd0);
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_count", 32'(dc0), 32'd0);
    chk("rst_ready", 32'(ir0), 32'd0);
    iv0 = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ir0), 32'd1);
    chk("post_rst_strobe", 32'(sd0), 32'd0);

    // single run, out_ready two cycles after out_valid
    run(2, 1'b0, 1);
    // backpressure with in_valid hammering
    run(20, 1'b1, 2);

    // flush during the second layer's settle window
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (6) tick();
    fl0 = 1'b1;
    tick();
    fl0 = 1'b0;
    chk("flush_ready", 32'(ir0), 32'd1);
    chk("flush_busy", 32'(bz0), 32'd0);
    chk("flush_strobe", 32'(sd0), 32'd0);
    chk("flush_layer", 32'(li0), 32'd0);
    chk("flush_count", 32'(dc0), 32'd2);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("flush_quiet", 32'(sd0), 32'd0);
    end

    run(0, 1'b0, 3);
    run(1, 1'b0, 4);
    run(0, 1'b0, 5);

    // TOTAL_LAYERS=2, LAYER_CYCLES=1
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    chk("fast_s0", 32'(sd1), 32'b001);
    chk("fast_v0", 32'(ov1), 32'd0);
    tick();
    chk("fast_s1", 32'(sd1), 32'b010);
    tick();
    chk("fast_s2", 32'(sd1), 32'b100);
    chk("fast_l2", 32'(li1), 32'd2);
    chk("fast_v2", 32'(ov1), 32'd0);
    tick();
    chk("fast_s3", 32'(sd1), 32'b000);
    chk("fast_v3", 32'(ov1), 32'd1);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    chk("fast_count", 32'(dc1), 32'd1);
    chk("fast_ready", 32'(ir1), 32'd1);

    // asynchronous reset mid-inference
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (5) tick();
    chk("pre_rst_strobe", 32'(sd0), 32'b0010);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_strobe", 32'(sd0), 32'd0);
    chk("mid_rst_busy", 32'(bz0), 32'd0);
    chk("mid_rst_count", 32'(dc0), 32'd0);
    chk("mid_rst_ready", 32'(ir0), 32'd0);
    chk("mid_rst_valid", 32'(ov0), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_ready", 32'(ir0), 32'd1);
    chk("rel_strobe", 32'(sd0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
